// File: rtl/reg_unit_sb_if.sv
// Bundle of issue, writeback and read-port signals for the register unit
// with scoreboard; master drives requests, slave returns data and hazards.
interface reg_unit_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_use;
    logic            rs2_use;
    logic            issue_valid;
    logic            issue_we;
    logic [AW-1:0]   rd_issue;
    logic            RuWr;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            stall;
    logic [NREG-1:0] wr_en;

    modport master (
        output rs1, rs2, rs1_use, rs2_use, issue_valid, issue_we, rd_issue,
               RuWr, wb_rd, wb_data, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, wr_en
    );

    modport slave (
        input  rs1, rs2, rs1_use, rs2_use, issue_valid, issue_we, rd_issue,
               RuWr, wb_rd, wb_data, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, wr_en
    );
endinterface

// File: rtl/reg_unit_sb.sv
// Register array with one-hot write decode, per-register pending-write
// counters for RAW/WAW hazard detection, and optional writeback bypass.
module reg_unit_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst_n,
    reg_unit_sb_if.slave bus
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [XLEN-1:0]   regs_r [NREG];
    logic [PEND_W-1:0] cnt_r  [NREG];
    logic [NREG-1:0]   wr_en_s;
    logic [NREG-1:0]   inc_s;
    logic [NREG-1:0]   dec_s;
    logic [XLEN-1:0]   rs1_data_s;
    logic [XLEN-1:0]   rs2_data_s;
    logic              rs1_busy_s;
    logic              rs2_busy_s;
    logic              rd_full_s;
    logic              stall_s;

    // One-hot write enable; index 0 never enabled
    always_comb begin
        wr_en_s = '0;
        if (bus.RuWr && (bus.wb_rd != '0)) begin
            wr_en_s[bus.wb_rd] = 1'b1;
        end else begin
            wr_en_s = '0;
        end
    end

    // Read port 1: zero register, then bypass, then storage
    always_comb begin
        rs1_data_s = '0;
        if (bus.rs1 == '0) begin
            rs1_data_s = '0;
        end else if ((BYPASS != 0) && bus.RuWr && (bus.wb_rd == bus.rs1)) begin
            rs1_data_s = bus.wb_data;
        end else begin
            rs1_data_s = regs_r[bus.rs1];
        end
    end

    // Read port 2: zero register, then bypass, then storage
    always_comb begin
        rs2_data_s = '0;
        if (bus.rs2 == '0) begin
            rs2_data_s = '0;
        end else if ((BYPASS != 0) && bus.RuWr && (bus.wb_rd == bus.rs2)) begin
            rs2_data_s = bus.wb_data;
        end else begin
            rs2_data_s = regs_r[bus.rs2];
        end
    end

    // Busy flags; a retiring last outstanding write clears busy when bypassed
    always_comb begin
        rs1_busy_s = 1'b0;
        rs2_busy_s = 1'b0;
        if (bus.rs1 == '0) begin
            rs1_busy_s = 1'b0;
        end else if ((BYPASS != 0) && bus.RuWr && (bus.wb_rd == bus.rs1) &&
                     (cnt_r[bus.rs1] == CNT_ONE)) begin
            rs1_busy_s = 1'b0;
        end else begin
            rs1_busy_s = (cnt_r[bus.rs1] != '0);
        end
        if (bus.rs2 == '0) begin
            rs2_busy_s = 1'b0;
        end else if ((BYPASS != 0) && bus.RuWr && (bus.wb_rd == bus.rs2) &&
                     (cnt_r[bus.rs2] == CNT_ONE)) begin
            rs2_busy_s = 1'b0;
        end else begin
            rs2_busy_s = (cnt_r[bus.rs2] != '0);
        end
    end

    // Stall on RAW hazard or on a saturated destination counter not retiring now
    always_comb begin
        rd_full_s = bus.issue_we && (bus.rd_issue != '0) &&
                    (cnt_r[bus.rd_issue] == CNT_MAX) &&
                    !(bus.RuWr && (bus.wb_rd == bus.rd_issue));
        stall_s   = bus.issue_valid &&
                    ((bus.rs1_use && rs1_busy_s) ||
                     (bus.rs2_use && rs2_busy_s) || rd_full_s);
    end

    // Per-register increment/decrement requests
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_s[i] = bus.issue_valid && bus.issue_we && !stall_s &&
                       (bus.rd_issue == AW'(i));
            dec_s[i] = bus.RuWr && (bus.wb_rd == AW'(i)) && (cnt_r[i] != '0);
        end
    end

    // Pending-write counters; flush wins over inc/dec
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_r[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NREG; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc_s[i] && !dec_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end else if (dec_s[i] && !inc_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - CNT_ONE;
                end
            end
        end
    end

    // Register array storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en_s[i]) regs_r[i] <= bus.wb_data;
            end
        end
    end

    assign bus.wr_en    = wr_en_s;
    assign bus.rs1_data = rs1_data_s;
    assign bus.rs2_data = rs2_data_s;
    assign bus.rs1_busy = rs1_busy_s;
    assign bus.rs2_busy = rs2_busy_s;
    assign bus.stall    = stall_s;
endmodule

// File: tb/tb_reg_unit_sb.sv
// Self-checking bench for reg_unit_sb: a bypassing and a non-bypassing
// instance share identical stimulus; read-back data is scoreboarded.
module tb_reg_unit_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    reg_unit_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus ();
    reg_unit_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus0 ();

    reg_unit_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .PEND_W(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    reg_unit_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .PEND_W(2), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    assign bus0.rs1         = bus.rs1;
    assign bus0.rs2         = bus.rs2;
    assign bus0.rs1_use     = bus.rs1_use;
    assign bus0.rs2_use     = bus.rs2_use;
    assign bus0.issue_valid = bus.issue_valid;
    assign bus0.issue_we    = bus.issue_we;
    assign bus0.rd_issue    = bus.rd_issue;
    assign bus0.RuWr        = bus.RuWr;
    assign bus0.wb_rd       = bus.wb_rd;
    assign bus0.wb_data     = bus.wb_data;
    assign bus0.flush       = bus.flush;

    always #5 clk = ~clk;

    task automatic idle();
        bus.rs1 = '0; bus.rs2 = '0; bus.rs1_use = 1'b0; bus.rs2_use = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_we = 1'b0; bus.rd_issue = '0;
        bus.RuWr = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.flush = 1'b0;
    endtask

    task automatic issue_wr(input logic [AW-1:0] rd);
        @(negedge clk);
        idle();
        bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.rd_issue = rd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            bus.rs1 = AW'(i); bus.rs2 = AW'(NREG - 1 - i);
            bus.rs1_use = 1'b1; bus.rs2_use = 1'b1; bus.issue_valid = 1'b1;
            #1;
            checks++;
            if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_data idx=%0d got %h/%h want 0", i, bus.rs1_data, bus.rs2_data);
            end
            checks++;
            if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy idx=%0d busy=%b%b stall=%b want 000",
                         i, bus.rs1_busy, bus.rs2_busy, bus.stall);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        bus.RuWr = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEADBEEF; bus.rs1 = 5'd0;
        #1;
        checks++;
        if (bus.wr_en !== 32'h0 || bus.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_write wr_en=%h data=%h want 0/0", bus.wr_en, bus.rs1_data);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_read got %h want 0", bus.rs1_data);
        end
    endtask

    task automatic test_scoreboard();
        logic [NREG-1:0] exp_en;
        logic [XLEN-1:0] d;
        exp_t e;
        apply_reset();
        for (int k = 1; k < NREG; k++) begin
            @(negedge clk);
            idle();
            d = $urandom;
            bus.RuWr = 1'b1; bus.wb_rd = AW'(k); bus.wb_data = d; bus.rs1 = AW'(k);
            e.idx = AW'(k); e.data = d;
            sb_q.push_back(e);
            exp_en = '0;
            exp_en[k] = 1'b1;
            #1;
            checks++;
            if (bus.wr_en !== exp_en) begin
                failures++;
                $display("FAIL wr_en idx=%0d got %h want %h", k, bus.wr_en, exp_en);
            end
            checks++;
            if (bus.rs1_data !== d || bus0.rs1_data !== 32'h0) begin
                failures++;
                $display("FAIL bypass idx=%0d got %h/%h want %h/0", k, bus.rs1_data, bus0.rs1_data, d);
            end
        end
        @(negedge clk);
        idle();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.rs1 = e.idx; bus.rs2 = e.idx;
            #1;
            checks++;
            if (bus.rs1_data !== e.data || bus.rs2_data !== e.data || bus0.rs1_data !== e.data) begin
                failures++;
                $display("FAIL readback idx=%0d got %h/%h/%h want %h",
                         e.idx, bus.rs1_data, bus.rs2_data, bus0.rs1_data, e.data);
            end
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        issue_wr(5'd5);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL haz_first_issue stall=%b want 0", bus.stall);
        end
        @(negedge clk);
        idle();
        bus.issue_valid = 1'b1; bus.rs1 = 5'd5; bus.rs1_use = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus0.stall !== 1'b1 || bus.rs1_busy !== 1'b1) begin
            failures++;
            $display("FAIL haz_raw stall=%b/%b busy=%b want 1/1/1", bus.stall, bus0.stall, bus.rs1_busy);
        end
        bus.RuWr = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rs1_data !== 32'h1234) begin
            failures++;
            $display("FAIL haz_bypass stall=%b data=%h want 0/00001234", bus.stall, bus.rs1_data);
        end
        checks++;
        if (bus0.stall !== 1'b1 || bus0.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL haz_nobypass stall=%b data=%h want 1/0", bus0.stall, bus0.rs1_data);
        end
        @(negedge clk);
        bus.RuWr = 1'b0;
        #1;
        checks++;
        if (bus0.stall !== 1'b0 || bus0.rs1_data !== 32'h1234 || bus.rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL haz_after stall0=%b data0=%h busy=%b want 0/00001234/0",
                     bus0.stall, bus0.rs1_data, bus.rs1_busy);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            issue_wr(5'd7);
            #1;
            checks++;
            if (bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL full_fill n=%0d stall=%b want 0", k, bus.stall);
            end
        end
        issue_wr(5'd7);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL full_stall stall=%b want 1", bus.stall);
        end
        bus.RuWr = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h77;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL full_retire stall=%b want 0", bus.stall);
        end
        issue_wr(5'd7);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL full_still3 stall=%b want 1", bus.stall);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            bus.RuWr = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h70 + 32'(k);
            @(negedge clk);
            idle();
            bus.rs2 = 5'd7;
            #1;
            checks++;
            if (bus.rs2_busy !== (k < 2)) begin
                failures++;
                $display("FAIL full_drain n=%0d busy=%b want %b", k, bus.rs2_busy, (k < 2));
            end
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        issue_wr(5'd9);
        issue_wr(5'd9);
        bus.RuWr = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h9999; bus.rs2 = 5'd9;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b0 || bus.stall !== 1'b0 || bus.rs2_data !== 32'h9999) begin
            failures++;
            $display("FAIL same_cycle busy=%b stall=%b data=%h want 0/0/00009999",
                     bus.rs2_busy, bus.stall, bus.rs2_data);
        end
        @(negedge clk);
        idle();
        bus.rs2 = 5'd9;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b1 || bus.rs2_data !== 32'h9999) begin
            failures++;
            $display("FAIL same_cycle_after busy=%b data=%h want 1/00009999", bus.rs2_busy, bus.rs2_data);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        issue_wr(5'd3);
        issue_wr(5'd3);
        issue_wr(5'd4);
        @(negedge clk);
        idle();
        bus.rs1 = 5'd3; bus.rs2 = 5'd4;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre busy=%b%b want 11", bus.rs1_busy, bus.rs2_busy);
        end
        bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.rd_issue = 5'd3;
        @(negedge clk);
        idle();
        bus.rs1 = 5'd3; bus.rs2 = 5'd4; bus.rs1_use = 1'b1; bus.rs2_use = 1'b1;
        bus.issue_valid = 1'b1;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear busy=%b%b stall=%b want 000", bus.rs1_busy, bus.rs2_busy, bus.stall);
        end
        @(negedge clk);
        idle();
        bus.RuWr = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hCAFE0003;
        @(negedge clk);
        idle();
        bus.rs1 = 5'd3;
        #1;
        checks++;
        if (bus.rs1_data !== 32'hCAFE0003 || bus.rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_underflow data=%h busy=%b want cafe0003/0", bus.rs1_data, bus.rs1_busy);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        idle();
        bus.RuWr = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h22;
        issue_wr(5'd6);
        @(negedge clk);
        idle();
        bus.rs1 = 5'd2; bus.rs2 = 5'd6; bus.rs2_use = 1'b1; bus.issue_valid = 1'b1;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h22 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre data=%h stall=%b want 00000022/1", bus.rs1_data, bus.stall);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0 || bus.rs2_busy !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL arst_clear data=%h busy=%b stall=%b want 0/0/0",
                     bus.rs1_data, bus.rs2_busy, bus.stall);
        end
        bus.RuWr = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33; bus.rs1 = 5'd3;
        #1;
        checks++;
        if (bus.wr_en !== 32'h8 || bus.rs1_data !== 32'h33) begin
            failures++;
            $display("FAIL arst_comb wr_en=%h data=%h want 00000008/00000033", bus.wr_en, bus.rs1_data);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        bus.RuWr = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h66;
        @(negedge clk);
        idle();
        bus.rs2 = 5'd6;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b0 || bus.rs2_data !== 32'h66) begin
            failures++;
            $display("FAIL arst_after busy=%b data=%h want 0/00000066", bus.rs2_busy, bus.rs2_data);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        checks = 0;
        failures = 0;
        idle();
        test_reset();
        test_scoreboard();
        test_hazard();
        test_full();
        test_same_cycle();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
